// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline.
//   NOP_INSTR     canonical bubble instruction (addi x0, x0, 0)
//   if_id_t       IF/ID pipeline register contents
//   IF_ID_BUBBLE  value loaded into IF/ID on reset or flush
// Further pipeline-register structs (ID/EX, EX/MEM, MEM/WB) belong here as well.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Update priority: reset, flush (bubble), stall (hold), load.
// The same structure is used for the later pipeline registers.
// Ports:
//   clk      in   pipeline clock, rising edge
//   i_reset  in   synchronous, active-high reset
//   i_stall  in   hold current contents
//   i_flush  in   load a bubble; beats i_stall
//   i_data   in   next-stage contents from IF
//   o_data   out  registered contents for ID
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   i_reset,
  input  logic   i_stall,
  input  logic   i_flush,
  input  if_id_t i_data,
  output if_id_t o_data
);

  if_id_t r_data;

  always_ff @(posedge clk) begin
    if (i_reset || i_flush) begin
      r_data <= IF_ID_BUBBLE;
    end else if (!i_stall) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline plus the IF/ID register.
// Owns the PC, drives the imem address, latches the fetched instruction and
// keeps saturating stall/flush debug counters and a sticky misaligned-target flag.
// Ports:
//   clk          in   pipeline clock, rising edge
//   reset        in   synchronous, active-high reset
//   StallF       in   hold PC
//   StallD       in   hold IF/ID
//   FlushD       in   squash IF/ID
//   PCSrcE       in   redirect fetch to PCTargetE
//   PCTargetE    in   branch/jump target from EX
//   InstrF       in   instruction read asynchronously from imem at PCF
//   PCF          out  current fetch address
//   InstrD       out  IF/ID instruction
//   PCD          out  IF/ID PC
//   PCPlus4D     out  IF/ID PC+4
//   ValidD       out  IF/ID holds a real instruction
//   MisalignErr  out  sticky: a redirect target was not word aligned
//   StallCnt     out  saturating count of cycles with PC held
//   FlushCnt     out  saturating count of cycles with IF/ID squashed
// XLEN must match riscv_pkg::XLEN since the IF/ID struct is sized from the package.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [XLEN-1:0]  PCF,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic [XLEN-1:0]  r_pcf;
  logic             r_misalign;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_pc_next;
  logic             w_stall_evt;
  if_id_t           w_if_id_in;
  if_id_t           w_if_id_out;

  // Carry out of the adder is dropped, so 0xFFFF_FFFC wraps to 0.
  assign w_pc_plus4 = r_pcf + {{(XLEN-3){1'b0}}, 3'd4};

  // Redirect beats stall; the loaded target is always word aligned.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (PCSrcE) begin
      w_pc_next = {PCTargetE[XLEN-1:2], 2'b00};
    end else if (StallF) begin
      w_pc_next = r_pcf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcf <= RESET_PC;
    end else begin
      r_pcf <= w_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  // A redirect overrides StallF, so the PC is not actually held in that cycle.
  assign w_stall_evt = StallF && !PCSrcE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (FlushD && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign w_if_id_in = '{
    instr:    InstrF,
    pc:       r_pcf,
    pc_plus4: w_pc_plus4,
    valid:    1'b1
  };

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .i_reset (reset),
    .i_stall (StallD),
    .i_flush (FlushD),
    .i_data  (w_if_id_in),
    .o_data  (w_if_id_out)
  );

  assign PCF         = r_pcf;
  assign InstrD      = w_if_id_out.instr;
  assign PCD         = w_if_id_out.pc;
  assign PCPlus4D    = w_if_id_out.pc_plus4;
  assign ValidD      = w_if_id_out.valid;
  assign MisalignErr = r_misalign;
  assign StallCnt    = r_stall_cnt;
  assign FlushCnt    = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed pipeline scenarios followed by random hazard traffic.
// The driver updates a reference model and queues the expected state; the monitor
// pops one entry after each rising edge and compares every output.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam int          CW      = 3;
  localparam int          CNT_MAX = (1 << CW) - 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0]   PCTargetE = '0;
  logic [31:0]   InstrF;
  logic [31:0]   PCF, InstrD, PCD, PCPlus4D;
  logic          ValidD, MisalignErr;
  logic [CW-1:0] StallCnt, FlushCnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory: every word is a hash of its address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  assign InstrF = imem_word(PCF);

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD),
    .MisalignErr (MisalignErr),
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt)
  );

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic        valid;
    logic        mis;
    int          scnt;
    int          fcnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus; the model state after the coming edge goes to the scoreboard.
  task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                      input logic ps, input logic [31:0] tgt);
    @(negedge clk);
    reset = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    if (rst) begin
      m.pcf = RST_PC; m.instr = NOP; m.pcd = 0; m.pcp4 = 0; m.valid = 0;
      m.mis = 0; m.scnt = 0; m.fcnt = 0;
    end else begin
      if (fd) begin
        m.instr = NOP; m.pcd = 0; m.pcp4 = 0; m.valid = 0;
      end else if (!sd) begin
        m.instr = imem_word(m.pcf); m.pcd = m.pcf; m.pcp4 = m.pcf + 32'd4; m.valid = 1;
      end
      if (ps && (tgt % 4 != 0)) m.mis = 1;
      if (sf && !ps) m.scnt = (m.scnt < CNT_MAX) ? m.scnt + 1 : CNT_MAX;
      if (fd)        m.fcnt = (m.fcnt < CNT_MAX) ? m.fcnt + 1 : CNT_MAX;
      if (ps)       m.pcf = tgt - (tgt % 4);
      else if (!sf) m.pcf = m.pcf + 32'd4;
    end
    sb.push_back(m);
  endtask

  task automatic free_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("PCF",         PCF,                e.pcf);
        chk("InstrD",      InstrD,             e.instr);
        chk("PCD",         PCD,                e.pcd);
        chk("PCPlus4D",    PCPlus4D,           e.pcp4);
        chk("ValidD",      32'(ValidD),        32'(e.valid));
        chk("MisalignErr", 32'(MisalignErr),   32'(e.mis));
        chk("StallCnt",    32'(StallCnt),      32'(e.scnt));
        chk("FlushCnt",    32'(FlushCnt),      32'(e.fcnt));
      end
    end
  end

  initial begin : driver
    logic        sf, sd, fd, ps, rst;
    logic [31:0] tgt;
    m = '{pcf: 0, instr: 0, pcd: 0, pcp4: 0, valid: 0, mis: 0, scnt: 0, fcnt: 0};

    // Reset for two cycles, then straight-line fetch 0x104, 0x108.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    free_cycle();
    free_cycle();
    // Load-use stall at 0x108, then resume.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    free_cycle();
    // Taken branch to 0x200 with squash of the wrong-path fetch.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    free_cycle();
    free_cycle();
    // Redirect beats stall; misaligned target sets the sticky flag.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0302);
    free_cycle();
    // Flush beats stall on IF/ID.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    // All three hazards at once.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    // PC wraps from the top of the address space.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    free_cycle();
    free_cycle();
    // Long stall saturates StallCnt, then reset lands mid-stall.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    free_cycle();
    // Flush saturation.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Random hazard traffic.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      sf  = ($urandom_range(0, 3) == 0);
      sd  = sf ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      ps  = ($urandom_range(0, 5) == 0);
      fd  = ps ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: tgt = {$urandom_range(0, 65535), 14'h0, 2'b00} | 32'($urandom_range(0, 3));
      endcase
      step(rst, sf, sd, fd, ps, tgt);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
